// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and constants for the program loader
package loader_pkg;

    // Loader sequencing states
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HI   = 3'd1,
        S_LO   = 3'd2,
        S_CHK  = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    // Sticky error codes reported on err_code
    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_FRAME = 2'd1;
    localparam logic [1:0] ERR_CSUM  = 2'd2;

    // IM word layout: {opcode[14:8], literal[7:0]}
    localparam int OP_W   = 7;
    localparam int LIT_W  = 8;
    localparam int OP_MSB = OP_W + LIT_W - 1;

endpackage

// File: rtl/xor_checksum.sv
// rtl/xor_checksum.sv - 8-bit XOR accumulator with clear, enable and match
module xor_checksum (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    input  logic [7:0] cmp,
    output logic [7:0] sum,
    output logic       match
);

    // Accumulate bytes; clear wins over a same-cycle enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= 8'h00;
        end else if (clr) begin
            sum <= 8'h00;
        end else if (en) begin
            sum <= sum ^ din;
        end
    end

    // Compare the running sum against the byte being offered
    always_comb begin
        match = (sum == cmp);
    end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed byte-stream loader into instruction memory
module program_loader #(
    parameter int ADDR_W = 8,
    parameter int OP_W   = loader_pkg::OP_W,
    parameter int LIT_W  = loader_pkg::LIT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic                  start,
    output logic                  im_we,
    output logic [ADDR_W-1:0]     im_waddr,
    output logic [OP_W+LIT_W-1:0] im_wdata,
    output logic                  cpu_run,
    output logic [1:0]            err_code,
    output logic [ADDR_W:0]       word_count
);

    import loader_pkg::*;

    state_t            state;
    state_t            state_nxt;
    logic              hs;
    logic              csum_clr;
    logic              csum_en;
    logic              csum_match;
    logic [7:0]        csum_sum;
    logic [ADDR_W:0]   n_words;
    logic [ADDR_W:0]   hdr_words;
    logic [ADDR_W:0]   wc_inc;
    logic [OP_W-1:0]   opcode;

    // A header of zero stands for a full 2^ADDR_W-word program
    always_comb begin
        hdr_words = (ADDR_W+1)'(in_data);
        if (in_data == 8'h00) begin
            hdr_words = (ADDR_W+1)'(1) << ADDR_W;
        end
        wc_inc = word_count + (ADDR_W+1)'(1);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start aborts from anywhere and eats any same-cycle byte
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = S_IDLE;
        end else if (hs) begin
            case (state)
                S_IDLE:  state_nxt = S_HI;
                S_HI:    state_nxt = in_data[7] ? S_ERR : S_LO;
                S_LO:    state_nxt = (wc_inc == n_words) ? S_CHK : S_HI;
                S_CHK:   state_nxt = csum_match ? S_DONE : S_ERR;
                default: state_nxt = state;
            endcase
        end
    end

    // Handshake and checksum controls depend only on registered state
    always_comb begin
        in_ready = (state == S_IDLE) || (state == S_HI) ||
                   (state == S_LO)   || (state == S_CHK);
        hs       = in_valid && in_ready && !start;
        csum_clr = start || (hs && (state == S_IDLE));
        csum_en  = hs && (((state == S_HI) && !in_data[7]) || (state == S_LO));
    end

    // Datapath: header latch, opcode latch, IM write, run/error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_words    <= '0;
            opcode     <= '0;
            im_we      <= 1'b0;
            im_waddr   <= '0;
            im_wdata   <= '0;
            cpu_run    <= 1'b0;
            err_code   <= ERR_NONE;
            word_count <= '0;
        end else begin
            im_we <= 1'b0;
            if (start) begin
                cpu_run    <= 1'b0;
                err_code   <= ERR_NONE;
                word_count <= '0;
            end else if (hs) begin
                case (state)
                    S_IDLE: begin
                        n_words    <= hdr_words;
                        word_count <= '0;
                    end
                    S_HI: begin
                        if (in_data[7]) begin
                            err_code <= ERR_FRAME;
                        end else begin
                            opcode <= in_data[OP_W-1:0];
                        end
                    end
                    S_LO: begin
                        im_we      <= 1'b1;
                        im_waddr   <= word_count[ADDR_W-1:0];
                        im_wdata   <= {opcode, in_data[LIT_W-1:0]};
                        word_count <= wc_inc;
                    end
                    S_CHK: begin
                        if (csum_match) begin
                            cpu_run <= 1'b1;
                        end else begin
                            err_code <= ERR_CSUM;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    xor_checksum u_csum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (csum_clr),
        .en    (csum_en),
        .din   (in_data),
        .cmp   (in_data),
        .sum   (csum_sum),
        .match (csum_match)
    );

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - self-checking bench for program_loader
module tb_program_loader;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              start = 1'b0;
    logic              im_we;
    logic [ADDR_W-1:0] im_waddr;
    logic [14:0]       im_wdata;
    logic              cpu_run;
    logic [1:0]        err_code;
    logic [ADDR_W:0]   word_count;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [22:0] sb[$];
    logic [7:0]  csum;
    int          wa;

    program_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .start      (start),
        .im_we      (im_we),
        .im_waddr   (im_waddr),
        .im_wdata   (im_wdata),
        .cpu_run    (cpu_run),
        .err_code   (err_code),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [22:0] e;
        @(posedge clk);
        #1;
        if (im_we === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_we", {31'd0, im_we}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("we_addr", {24'd0, im_waddr}, {24'd0, e[22:15]});
                chk("we_data", {17'd0, im_wdata}, {17'd0, e[14:0]});
            end
        end
    endtask

    task automatic send(input logic [7:0] b);
        logic rdy;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 100; i++) begin
            rdy = in_ready;
            step();
            if (rdy) begin
                in_valid = 1'b0;
                return;
            end
        end
        chk("ready_timeout", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic begin_load(input logic [7:0] n);
        csum = 8'h00;
        wa   = 0;
        send(n);
    endtask

    task automatic word(input logic [6:0] op, input logic [7:0] lit);
        send({1'b0, op});
        csum = csum ^ {1'b0, op} ^ lit;
        sb.push_back({wa[7:0], op, lit});
        wa++;
        send(lit);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic load_test_prog(input logic [7:0] last);
        begin_load(8'h02);
        word(7'h02, 8'h05);
        word(7'h53, 8'h00);
        send(last);
    endtask

    initial begin
        // Reset values while reset is held
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_im_we", {31'd0, im_we}, 32'd0);
        chk("rst_im_waddr", {24'd0, im_waddr}, 32'd0);
        chk("rst_im_wdata", {17'd0, im_wdata}, 32'd0);
        chk("rst_cpu_run", {31'd0, cpu_run}, 32'd0);
        chk("rst_err_code", {30'd0, err_code}, 32'd0);
        chk("rst_word_count", {23'd0, word_count}, 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // Valid two-word load
        load_test_prog(8'h54);
        chk("csum_model", {24'd0, csum}, 32'h54);
        chk("ok_cpu_run", {31'd0, cpu_run}, 32'd1);
        chk("ok_err_code", {30'd0, err_code}, 32'd0);
        chk("ok_word_count", {23'd0, word_count}, 32'd2);
        chk("ok_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        chk("ok_sb_drained", sb.size(), 32'd0);

        // Bad checksum
        pulse_start();
        chk("st_cpu_run", {31'd0, cpu_run}, 32'd0);
        chk("st_word_count", {23'd0, word_count}, 32'd0);
        load_test_prog(8'h55);
        chk("bad_err_code", {30'd0, err_code}, 32'd2);
        chk("bad_cpu_run", {31'd0, cpu_run}, 32'd0);
        chk("bad_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bad_sb_drained", sb.size(), 32'd0);

        // Framing error, then recovery by start
        pulse_start();
        begin_load(8'h01);
        send(8'h80);
        step();
        chk("frm_err_code", {30'd0, err_code}, 32'd1);
        chk("frm_in_ready", {31'd0, in_ready}, 32'd0);
        chk("frm_word_count", {23'd0, word_count}, 32'd0);
        pulse_start();
        chk("frm_clr_err", {30'd0, err_code}, 32'd0);
        chk("frm_clr_ready", {31'd0, in_ready}, 32'd1);

        // Full 256-word program with random valid gaps
        begin_load(8'h00);
        for (int i = 0; i < 256; i++) begin
            repeat ($urandom_range(0, 2)) step();
            word(7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)));
            chk("full_no_run_early", {31'd0, cpu_run}, 32'd0);
        end
        repeat ($urandom_range(0, 3)) step();
        send(csum);
        chk("full_word_count", {23'd0, word_count}, 32'd256);
        chk("full_cpu_run", {31'd0, cpu_run}, 32'd1);
        chk("full_err_code", {30'd0, err_code}, 32'd0);
        chk("full_sb_drained", sb.size(), 32'd0);

        // Abort with start on the second word's LO byte
        pulse_start();
        begin_load(8'h02);
        word(7'h11, 8'h22);
        send(8'h33);
        in_valid = 1'b1;
        in_data  = 8'h44;
        start    = 1'b1;
        step();
        start    = 1'b0;
        in_valid = 1'b0;
        chk("abort_word_count", {23'd0, word_count}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk("abort_no_we", {31'd0, im_we}, 32'd0);
        begin_load(8'h01);
        word(7'h7F, 8'hFF);
        send(csum);
        chk("abort_reload_run", {31'd0, cpu_run}, 32'd1);
        chk("abort_reload_wc", {23'd0, word_count}, 32'd1);
        chk("abort_sb_drained", sb.size(), 32'd0);

        // Asynchronous reset after the third byte
        pulse_start();
        begin_load(8'h02);
        word(7'h01, 8'h02);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_im_we", {31'd0, im_we}, 32'd0);
        chk("arst_im_waddr", {24'd0, im_waddr}, 32'd0);
        chk("arst_im_wdata", {17'd0, im_wdata}, 32'd0);
        chk("arst_word_count", {23'd0, word_count}, 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        load_test_prog(8'h54);
        chk("arst_reload_run", {31'd0, cpu_run}, 32'd1);
        chk("arst_reload_wc", {23'd0, word_count}, 32'd2);
        step();
        chk("final_sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
